// File: rtl/ex_resolve_stage.sv
// EX-stage back end: final result select, branch resolution, EX/MEM register with handshake,
// and taken-branch redirect/squash. Optional sticky overflow flag under `EX_STICKY_OVF_EN.
module ex_resolve_stage #(
    parameter int KILL_SLOTS = 2,
    parameter int CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_i,
    input  logic [31:0] s_i,
    input  logic        c_i,
    input  logic        v_i,
    input  logic        z_i,
    input  logic        n_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
`ifdef EX_STICKY_OVF_EN
    input  logic        ovf_clr_i,
    output logic        ovf_sticky_o,
`endif
    output logic        squash_o
);
    localparam logic [3:0] OP_SLT  = 4'd1;
    localparam logic [3:0] OP_SLTU = 4'd2;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_BLT  = 4'd10;
    localparam logic [3:0] OP_BGE  = 4'd11;
    localparam logic [3:0] OP_BLTU = 4'd12;
    localparam logic [3:0] OP_BGEU = 4'd13;

    localparam bit             SQUASH_EN = (KILL_SLOTS > 0);
    localparam logic [CNT_W-1:0] KILL_CNT = CNT_W'(KILL_SLOTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, SQUASH = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic        out_valid_reg;
    logic [31:0] result_reg;
    logic [4:0]  rd_reg;
    logic [31:0] pc_reg;
    logic        redirect_reg;
    logic [31:0] redirect_pc_reg;

    logic        accept;
    logic        load;
    logic        is_branch;
    logic        taken;
    logic [31:0] result;

    assign in_ready = ~out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;

    // Compare/branch ops see A-B from the adder, so flags encode signed/unsigned order.
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        result    = s_i;
        case (op_i)
            OP_SLT:  result = {31'b0, n_i ^ v_i};
            OP_SLTU: result = {31'b0, ~c_i};
            OP_BEQ:  begin is_branch = 1'b1; taken = z_i;          end
            OP_BNE:  begin is_branch = 1'b1; taken = ~z_i;         end
            OP_BLT:  begin is_branch = 1'b1; taken = n_i ^ v_i;    end
            OP_BGE:  begin is_branch = 1'b1; taken = ~(n_i ^ v_i); end
            OP_BLTU: begin is_branch = 1'b1; taken = ~c_i;         end
            OP_BGEU: begin is_branch = 1'b1; taken = c_i;          end
            default: result = s_i;
        endcase
        if (is_branch) begin
            result = pc_i + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush_i) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && taken && SQUASH_EN) begin
                        state_next = SQUASH;
                        cnt_next   = KILL_CNT;
                    end
                end
                SQUASH: begin
                    if (accept) begin
                        cnt_next = cnt_reg - CNT_ONE;
                        if (cnt_reg == CNT_ONE) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Only beats accepted in IDLE and not killed by a flush reach the output register.
    always_comb begin
        squash_o = (state_reg == SQUASH);
        load     = accept & ~flush_i & (state_reg == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            result_reg      <= '0;
            rd_reg          <= '0;
            pc_reg          <= '0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            if (flush_i) begin
                out_valid_reg <= 1'b0;
            end else if (load) begin
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (load) begin
                result_reg <= result;
                rd_reg     <= is_branch ? 5'd0 : rd_i;
                pc_reg     <= pc_i;
            end
            redirect_reg <= load & taken;
            if (load & taken) begin
                redirect_pc_reg <= target_i;
            end
        end
    end

`ifdef EX_STICKY_OVF_EN
    logic is_pass;
    logic ovf_reg;

    assign is_pass = (op_i != OP_SLT) && (op_i != OP_SLTU) && !is_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (load && is_pass && v_i) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf_sticky_o = ovf_reg;
`endif

    assign out_valid     = out_valid_reg;
    assign out_result    = result_reg;
    assign out_rd        = rd_reg;
    assign out_pc        = pc_reg;
    assign redirect_o    = redirect_reg;
    assign redirect_pc_o = redirect_pc_reg;

endmodule

// File: tb/tb_ex_resolve_stage.sv
// Bench for ex_resolve_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model built from operand values.
module tb_ex_resolve_stage;
    localparam int KILL = 2;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_i;
    logic [31:0] s_i;
    logic        c_i, v_i, z_i, n_i;
    logic [4:0]  rd_i;
    logic [31:0] pc_i;
    logic [31:0] target_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        squash_o;

    // operands behind the current compare/branch beat
    logic [31:0] a_val, b_val;

    // model expectations for the outputs after the most recent edge
    logic        m_valid;
    logic [31:0] m_result;
    logic [4:0]  m_rd;
    logic [31:0] m_pc;
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic        m_squash;
    int          m_drop;

    int checks;
    int errors;
    bit chk_en;

    ex_resolve_stage #(.KILL_SLOTS(KILL), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_i(op_i), .s_i(s_i), .c_i(c_i), .v_i(v_i), .z_i(z_i), .n_i(n_i),
        .rd_i(rd_i), .pc_i(pc_i), .target_i(target_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_pc(out_pc),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .squash_o(squash_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted beat either consumes one pending drop or becomes the output beat.
    always @(posedge clk) begin : model
        logic        acc, br, tk, nv, nred;
        logic [31:0] res, nres, npc, nrpc;
        logic [4:0]  nrd;
        int          ndrop;
        acc = in_valid && (!m_valid || out_ready);
        br  = 1'b0;
        tk  = 1'b0;
        res = s_i;
        case (op_i)
            4'd1:  res = 32'($signed(a_val) < $signed(b_val));
            4'd2:  res = 32'(a_val < b_val);
            4'd8:  begin br = 1'b1; tk = (a_val == b_val); end
            4'd9:  begin br = 1'b1; tk = (a_val != b_val); end
            4'd10: begin br = 1'b1; tk = ($signed(a_val) < $signed(b_val)); end
            4'd11: begin br = 1'b1; tk = ($signed(a_val) >= $signed(b_val)); end
            4'd12: begin br = 1'b1; tk = (a_val < b_val); end
            4'd13: begin br = 1'b1; tk = (a_val >= b_val); end
            default: res = s_i;
        endcase
        if (br) res = pc_i + 32'd4;
        nv    = m_valid && !out_ready;
        nres  = m_result;
        nrd   = m_rd;
        npc   = m_pc;
        nred  = 1'b0;
        nrpc  = m_rpc;
        ndrop = m_drop;
        if (rst) begin
            nv = 1'b0; nres = '0; nrd = '0; npc = '0; nrpc = '0; ndrop = 0;
        end else if (flush_i) begin
            nv = 1'b0; ndrop = 0;
        end else if (acc) begin
            if (m_drop > 0) begin
                ndrop = m_drop - 1;
            end else begin
                nv   = 1'b1;
                nres = res;
                nrd  = br ? 5'd0 : rd_i;
                npc  = pc_i;
                if (tk) begin
                    nred  = 1'b1;
                    nrpc  = target_i;
                    ndrop = KILL;
                end
            end
        end
        m_valid    <= nv;
        m_result   <= nres;
        m_rd       <= nrd;
        m_pc       <= npc;
        m_redirect <= nred;
        m_rpc      <= nrpc;
        m_drop     <= ndrop;
        m_squash   <= (ndrop > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("cmp_out_result", out_result, m_result);
                check("cmp_out_rd", 32'(out_rd), 32'(m_rd));
                check("cmp_out_pc", out_pc, m_pc);
            end
            check("cmp_redirect", 32'(redirect_o), 32'(m_redirect));
            if (m_redirect) check("cmp_redirect_pc", redirect_pc_o, m_rpc);
            check("cmp_squash", 32'(squash_o), 32'(m_squash));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic [4:0] rd);
        logic [32:0] d;
        d        = {1'b0, a} + {1'b0, ~b} + 33'd1;
        op_i     = op;
        s_i      = d[31:0];
        c_i      = d[32];
        z_i      = (d[31:0] == 32'd0);
        n_i      = d[31];
        v_i      = (a[31] != b[31]) && (d[31] != a[31]);
        a_val    = a;
        b_val    = b;
        pc_i     = pc;
        target_i = tgt;
        rd_i     = rd;
        in_valid = 1'b1;
    endtask

    task automatic set_pass(input logic [3:0] op, input logic [31:0] s, input logic [4:0] rd,
                            input logic [31:0] pc);
        op_i     = op;
        s_i      = s;
        c_i      = 1'($urandom);
        v_i      = 1'($urandom);
        z_i      = 1'($urandom);
        n_i      = 1'($urandom);
        rd_i     = rd;
        pc_i     = pc;
        target_i = $urandom;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, pc;
        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_i = '0; s_i = '0; c_i = 0; v_i = 0; z_i = 0; n_i = 0;
        rd_i = '0; pc_i = '0; target_i = '0; a_val = '0; b_val = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_redirect", 32'(redirect_o), 32'd0);
        check("rst_squash", 32'(squash_o), 32'd0);
        rst = 1'b0;

        set_pass(4'd0, 32'h0000_1234, 5'd5, 32'h40);
        tick();
        check("pass_valid", 32'(out_valid), 32'd1);
        check("pass_result", out_result, 32'h0000_1234);
        check("pass_rd", 32'(out_rd), 32'd5);

        set_cmp(4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h44, 32'h0, 5'd6);
        tick();
        check("slt_result", out_result, 32'd0);
        set_cmp(4'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h48, 32'h0, 5'd7);
        tick();
        check("sltu_result", out_result, 32'd1);

        set_cmp(4'd8, 32'd7, 32'd7, 32'h100, 32'h200, 5'd9);
        tick();
        check("beq_redirect", 32'(redirect_o), 32'd1);
        check("beq_redirect_pc", redirect_pc_o, 32'h200);
        check("beq_result", out_result, 32'h104);
        check("beq_rd", 32'(out_rd), 32'd0);
        check("beq_squash", 32'(squash_o), 32'd1);
        set_pass(4'd0, 32'hA, 5'd1, 32'h200);
        tick();
        check("drop1_valid", 32'(out_valid), 32'd0);
        check("drop1_redirect", 32'(redirect_o), 32'd0);
        set_pass(4'd0, 32'hB, 5'd1, 32'h204);
        tick();
        check("drop2_valid", 32'(out_valid), 32'd0);
        check("drop2_squash", 32'(squash_o), 32'd0);
        set_pass(4'd0, 32'hC, 5'd1, 32'h208);
        tick();
        check("third_valid", 32'(out_valid), 32'd1);
        check("third_result", out_result, 32'hC);

        out_ready = 1'b0;
        set_pass(4'd0, 32'hD, 5'd2, 32'h20C);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_result", out_result, 32'hC);
            check("stall_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("b2b_first", out_result, 32'hD);
        set_pass(4'd0, 32'hE, 5'd2, 32'h210);
        tick();
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second", out_result, 32'hE);

        set_cmp(4'd9, 32'd1, 32'd2, 32'h300, 32'h400, 5'd3);
        tick();
        check("bne_redirect_pc", redirect_pc_o, 32'h400);
        set_pass(4'd0, 32'h11, 5'd4, 32'h400);
        tick();
        check("sq1_squash", 32'(squash_o), 32'd1);
        in_valid = 1'b0;
        flush_i  = 1'b1;
        tick();
        check("flush_squash", 32'(squash_o), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        flush_i = 1'b0;
        set_pass(4'd0, 32'h55, 5'd4, 32'h404);
        tick();
        check("post_flush_result", out_result, 32'h55);
        check("post_flush_valid", 32'(out_valid), 32'd1);

        flush_i = 1'b1;
        set_cmp(4'd9, 32'd1, 32'd2, 32'h500, 32'h600, 5'd3);
        tick();
        check("flush_bne_redirect", 32'(redirect_o), 32'd0);
        check("flush_bne_valid", 32'(out_valid), 32'd0);
        flush_i  = 1'b0;
        in_valid = 1'b0;
        tick();

        out_ready = 1'b0;
        set_cmp(4'd8, 32'd5, 32'd5, 32'h500, 32'h600, 5'd3);
        tick();
        check("pre_rst_squash", 32'(squash_o), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", out_pc, 32'd0);
        check("mid_rst_squash", 32'(squash_o), 32'd0);
        check("mid_rst_rpc", redirect_pc_o, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        set_pass(4'd0, 32'h77, 5'd8, 32'h700);
        tick();
        check("post_rst_result", out_result, 32'h77);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush_i   = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 4'($urandom_range(0, 15));
            pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            a         = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a + 32'd1;
                2:       b = {~a[31], a[30:0]};
                default: b = $urandom;
            endcase
            if (op == 4'd1 || op == 4'd2 || (op >= 4'd8 && op <= 4'd13))
                set_cmp(op, a, b, pc, $urandom, 5'($urandom));
            else
                set_pass(op, $urandom, 5'($urandom), pc);
            in_valid = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
